player_physics: RTL and testbench

//  Per-player motion engine, one instance per player, stepped once per frame_clk (vsync) edge.

---
 rtl/player_pkg.sv | 20 ++
 rtl/key_match.sv | 32 +++
 rtl/player_physics.sv | 233 +++++++++++++++++++++++
 tb/tb_player_physics.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/player_pkg.sv
// player_pkg: shared types and default limits for the per-player motion engine.
// PLAYER_COYOTE_EN enables the coyote-time jump grace counter.
package player_pkg;

    typedef enum logic [1:0] {GROUND, RISE, FALL} move_state_t;
    typedef logic [7:0] keycode_t;

    localparam int KEY_SLOTS_DEF  = 4;
    localparam int POS_W_DEF      = 12;
    localparam int X_MIN_DEF      = 20;
    localparam int X_MAX_DEF      = 620;
    localparam int Y_MIN_DEF      = 25;
    localparam int Y_MAX_DEF      = 455;
    localparam int X_STEP_DEF     = 1;
    localparam int GRAVITY_DEF    = 1;
    localparam int JUMP_SPEED_DEF = 16;
    localparam int V_MAX_DEF      = 12;
    localparam int COYOTE_FRAMES  = 4;

endpackage

// File: rtl/key_match.sv
// key_match: scans the keycode slots for this player's left/right/jump bindings.
// Purely combinational; a 0x00 binding is treated as unbound.
module key_match
    import player_pkg::*;
#(
    parameter int KEY_SLOTS = KEY_SLOTS_DEF
) (
    input  logic [8*KEY_SLOTS-1:0] keycodes,
    input  logic [7:0]             key_left,
    input  logic [7:0]             key_right,
    input  logic [7:0]             key_jump,
    output logic                   left_held,
    output logic                   right_held,
    output logic                   jump_held
);

    function automatic logic held(
        input logic [8*KEY_SLOTS-1:0] kc,
        input keycode_t               binding
    );
        held = 1'b0;
        for (int i = 0; i < KEY_SLOTS; i++) begin
            if (binding != 8'h00 && kc[8*i +: 8] == binding)
                held = 1'b1;
        end
    endfunction

    assign left_held  = held(keycodes, key_left);
    assign right_held = held(keycodes, key_right);
    assign jump_held  = held(keycodes, key_jump);

endmodule

// File: rtl/player_physics.sv
// player_physics: per-player GROUND/RISE/FALL motion engine stepped on frame_clk.
// Define PLAYER_COYOTE_EN to allow a late jump for a few frames after walking off a ledge.
module player_physics
    import player_pkg::*;
#(
    parameter int KEY_SLOTS  = KEY_SLOTS_DEF,
    parameter int POS_W      = POS_W_DEF,
    parameter int X_MIN      = X_MIN_DEF,
    parameter int X_MAX      = X_MAX_DEF,
    parameter int Y_MIN      = Y_MIN_DEF,
    parameter int Y_MAX      = Y_MAX_DEF,
    parameter int X_STEP     = X_STEP_DEF,
    parameter int GRAVITY    = GRAVITY_DEF,
    parameter int JUMP_SPEED = JUMP_SPEED_DEF,
    parameter int V_MAX      = V_MAX_DEF
) (
    input  logic                   frame_clk,
    input  logic                   Reset_n,
    input  logic [8*KEY_SLOTS-1:0] keycodes,
    input  logic [7:0]             key_left,
    input  logic [7:0]             key_right,
    input  logic [7:0]             key_jump,
    input  logic [POS_W-1:0]       spawn_x,
    input  logic [POS_W-1:0]       spawn_y,
    input  logic [POS_W-1:0]       scroll_x,
    input  logic                   blocked_x,
    input  logic                   blocked_y,
    input  logic                   on_platform,
    input  logic [POS_W-1:0]       platform_y,
    input  logic                   carry_en,
    input  logic [POS_W-1:0]       carry_dx,
    output logic [POS_W-1:0]       pos_x,
    output logic [POS_W-1:0]       pos_y,
    output logic [POS_W-1:0]       next_x,
    output logic [POS_W-1:0]       next_y,
    output logic [POS_W-1:0]       vel_y,
    output logic [POS_W-1:0]       dx,
    output logic                   facing_right,
    output logic                   airborne,
    output logic                   died
);

    typedef logic signed [POS_W-1:0] spos_t;

    localparam spos_t X_MIN_S  = X_MIN[POS_W-1:0];
    localparam spos_t X_MAX_S  = X_MAX[POS_W-1:0];
    localparam spos_t Y_MIN_S  = Y_MIN[POS_W-1:0];
    localparam spos_t Y_MAX_S  = Y_MAX[POS_W-1:0];
    localparam spos_t STEP_S   = X_STEP[POS_W-1:0];
    localparam spos_t GRAV_S   = GRAVITY[POS_W-1:0];
    localparam spos_t JUMP_S   = JUMP_SPEED[POS_W-1:0];
    localparam spos_t V_MAX_S  = V_MAX[POS_W-1:0];

    move_state_t state, state_nx;
    spos_t px, py, vy, dx_q;
    spos_t dx_cmd, carry_add, nx, ny, rel, x_lim;
    spos_t px_nx, py_nx, vy_nx, vy_up, vy_fall, dx_nx;
    logic  left_held, right_held, jump_held;
    logic  jump_prev, jump_edge, face_q, face_nx, respawn;

`ifdef PLAYER_COYOTE_EN
    localparam int CW = $clog2(COYOTE_FRAMES + 1);
    logic [CW-1:0] coy_q, coy_nx;
`endif

    key_match #(.KEY_SLOTS(KEY_SLOTS)) u_keys (
        .keycodes   (keycodes),
        .key_left   (key_left),
        .key_right  (key_right),
        .key_jump   (key_jump),
        .left_held  (left_held),
        .right_held (right_held),
        .jump_held  (jump_held)
    );

    assign jump_edge = jump_held & ~jump_prev;

    // Opposing keys cancel and leave facing alone.
    always_comb begin
        dx_cmd  = '0;
        face_nx = face_q;
        unique case (1'b1)
            left_held & ~right_held: begin
                dx_cmd  = -STEP_S;
                face_nx = 1'b0;
            end
            right_held & ~left_held: begin
                dx_cmd  = STEP_S;
                face_nx = 1'b1;
            end
            default: ;
        endcase
    end

    assign carry_add = carry_en ? carry_dx : '0;
    assign nx        = px + dx_cmd + carry_add;
    assign rel       = nx - scroll_x;
    assign ny        = py + vy;
    assign vy_up     = vy + GRAV_S;
    assign vy_fall   = (vy_up > V_MAX_S) ? V_MAX_S : vy_up;

    // Screen clamp takes precedence over a horizontal collision.
    always_comb begin
        if (rel > X_MAX_S)
            x_lim = X_MAX_S + scroll_x;
        else if (rel < X_MIN_S)
            x_lim = X_MIN_S + scroll_x;
        else if (blocked_x)
            x_lim = px;
        else
            x_lim = nx;
    end

    always_comb begin
        state_nx = state;
        py_nx    = py;
        vy_nx    = vy;
        respawn  = 1'b0;
`ifdef PLAYER_COYOTE_EN
        coy_nx   = coy_q;
`endif
        if (ny >= Y_MAX_S) begin
            respawn  = 1'b1;
            py_nx    = spawn_y;
            vy_nx    = '0;
            state_nx = FALL;
`ifdef PLAYER_COYOTE_EN
            coy_nx   = '0;
`endif
        end else if (ny < Y_MIN_S) begin
            py_nx    = Y_MIN_S;
            vy_nx    = '0;
            state_nx = FALL;
        end else begin
            unique case (state)
                GROUND: begin
                    if (jump_edge) begin
                        vy_nx    = -JUMP_S;
                        state_nx = RISE;
                    end else if (!blocked_y && !on_platform) begin
                        vy_nx    = GRAV_S;
                        state_nx = FALL;
`ifdef PLAYER_COYOTE_EN
                        coy_nx   = CW'(COYOTE_FRAMES);
`endif
                    end else begin
                        vy_nx = '0;
                        if (on_platform)
                            py_nx = platform_y;
                    end
                end
                RISE: begin
                    if (blocked_y) begin
                        vy_nx    = '0;
                        state_nx = FALL;
                    end else begin
                        py_nx = ny;
                        vy_nx = vy_up;
                        if (!vy_up[POS_W-1])
                            state_nx = FALL;
                    end
                end
                FALL: begin
`ifdef PLAYER_COYOTE_EN
                    if (jump_edge && coy_q != '0) begin
                        vy_nx    = -JUMP_S;
                        state_nx = RISE;
                        coy_nx   = '0;
                    end else
`endif
                    if (blocked_y || on_platform) begin
                        vy_nx    = '0;
                        state_nx = GROUND;
                        if (on_platform)
                            py_nx = platform_y;
`ifdef PLAYER_COYOTE_EN
                        coy_nx   = '0;
`endif
                    end else begin
                        py_nx = ny;
                        vy_nx = vy_fall;
`ifdef PLAYER_COYOTE_EN
                        if (coy_q != '0)
                            coy_nx = coy_q - CW'(1);
`endif
                    end
                end
                default: state_nx = FALL;
            endcase
        end
    end

    assign px_nx = respawn ? spawn_x : x_lim;
    assign dx_nx = px_nx - px;

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            px        <= spawn_x;
            py        <= spawn_y;
            vy        <= '0;
            dx_q      <= '0;
            state     <= FALL;
            face_q    <= 1'b1;
            died      <= 1'b0;
            jump_prev <= 1'b0;
`ifdef PLAYER_COYOTE_EN
            coy_q     <= '0;
`endif
        end else begin
            px        <= px_nx;
            py        <= py_nx;
            vy        <= vy_nx;
            dx_q      <= dx_nx;
            state     <= state_nx;
            face_q    <= face_nx;
            died      <= respawn;
            jump_prev <= jump_held;
`ifdef PLAYER_COYOTE_EN
            coy_q     <= coy_nx;
`endif
        end
    end

    assign pos_x        = px;
    assign pos_y        = py;
    assign next_x       = nx;
    assign next_y       = ny;
    assign vel_y        = vy;
    assign dx           = dx_q;
    assign facing_right = face_q;
    assign airborne     = (state != GROUND);

endmodule

// File: tb/tb_player_physics.sv
// tb_player_physics: directed frames with hand-computed expectations,
// checked by a queue-draining monitor one step after each frame edge.
module tb_player_physics;

    typedef struct {
        string              name;
        logic signed [11:0] x;
        logic signed [11:0] y;
        logic signed [11:0] v;
        logic signed [11:0] dx;
        logic               f;
        logic               a;
        logic               d;
    } exp_t;

    logic        frame_clk = 1'b0;
    logic        Reset_n;
    logic [31:0] keycodes;
    logic [7:0]  key_left, key_right, key_jump;
    logic [11:0] spawn_x, spawn_y, scroll_x, platform_y, carry_dx;
    logic        blocked_x, blocked_y, on_platform, carry_en;
    logic [11:0] pos_x, pos_y, next_x, next_y, vel_y, dx;
    logic        facing_right, airborne, died;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    player_physics dut (
        .frame_clk    (frame_clk),
        .Reset_n      (Reset_n),
        .keycodes     (keycodes),
        .key_left     (key_left),
        .key_right    (key_right),
        .key_jump     (key_jump),
        .spawn_x      (spawn_x),
        .spawn_y      (spawn_y),
        .scroll_x     (scroll_x),
        .blocked_x    (blocked_x),
        .blocked_y    (blocked_y),
        .on_platform  (on_platform),
        .platform_y   (platform_y),
        .carry_en     (carry_en),
        .carry_dx     (carry_dx),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .next_x       (next_x),
        .next_y       (next_y),
        .vel_y        (vel_y),
        .dx           (dx),
        .facing_right (facing_right),
        .airborne     (airborne),
        .died         (died)
    );

    always #5 frame_clk = ~frame_clk;

    // Right in slot 3, jump in slot 2, left in slot 0.
    task automatic set_keys(input bit l, input bit r, input bit j);
        keycodes = {r ? 8'h07 : 8'h00, j ? 8'h2C : 8'h00,
                    8'h00, l ? 8'h04 : 8'h00};
    endtask

    task automatic push(input string n, input int x, input int y,
                        input int v, input int ddx,
                        input bit f, input bit a, input bit d);
        exp_t e;
        e.name = n;
        e.x    = x[11:0];
        e.y    = y[11:0];
        e.v    = v[11:0];
        e.dx   = ddx[11:0];
        e.f    = f;
        e.a    = a;
        e.d    = d;
        q.push_back(e);
    endtask

    task automatic frame(input string n, input int x, input int y,
                         input int v, input int ddx,
                         input bit f, input bit a, input bit d);
        push(n, x, y, v, ddx, f, a, d);
        @(negedge frame_clk);
    endtask

    task automatic do_reset(input string n, input int x, input int y);
        push(n, x, y, 0, 0, 1'b1, 1'b1, 1'b0);
        #2 Reset_n = 1'b0;
        @(negedge frame_clk);
        Reset_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t               e;
        logic signed [11:0] eny;
        bit                 ok;
        forever begin
            @(posedge frame_clk or negedge Reset_n);
            #1;
            if (q.size() > 0) begin
                e   = q.pop_front();
                eny = e.y + e.v;
                ok  = (pos_x == e.x) && (pos_y == e.y) &&
                      (vel_y == e.v) && (dx == e.dx) &&
                      (facing_right == e.f) && (airborne == e.a) &&
                      (died == e.d) && (next_y == eny);
                tests++;
                if (!ok) begin
                    fails++;
                    $display("FAIL %s: got x=%0d y=%0d v=%0d dx=%0d f=%0b a=%0b d=%0b ny=%0d nx=%0d; want x=%0d y=%0d v=%0d dx=%0d f=%0b a=%0b d=%0b ny=%0d",
                             e.name, $signed(pos_x), $signed(pos_y),
                             $signed(vel_y), $signed(dx), facing_right,
                             airborne, died, $signed(next_y),
                             $signed(next_x), e.x, e.y, e.v, e.dx,
                             e.f, e.a, e.d, eny);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int ey, ev;
        Reset_n     = 1'b1;
        keycodes    = '0;
        key_left    = 8'h04;
        key_right   = 8'h07;
        key_jump    = 8'h2C;
        spawn_x     = 12'd100;
        spawn_y     = 12'd200;
        scroll_x    = '0;
        platform_y  = '0;
        carry_dx    = '0;
        blocked_x   = 1'b0;
        blocked_y   = 1'b0;
        on_platform = 1'b0;
        carry_en    = 1'b0;

        do_reset("reset", 100, 200);

        blocked_y = 1'b1;
        frame("land", 100, 200, 0, 0, 1, 0, 0);

        key_left = 8'h00;
        set_keys(0, 1, 0);
        frame("bind_zero", 101, 200, 0, 1, 1, 0, 0);
        key_left = 8'h04;
        set_keys(1, 0, 0);
        frame("left", 100, 200, 0, -1, 0, 0, 0);
        set_keys(1, 1, 0);
        frame("both", 100, 200, 0, 0, 0, 0, 0);
        set_keys(0, 1, 0);
        blocked_x = 1'b1;
        frame("blocked_x", 100, 200, 0, 0, 1, 0, 0);
        blocked_x = 1'b0;
        set_keys(0, 0, 0);
        carry_en = 1'b1;
        carry_dx = 12'd5;
        frame("carry", 105, 200, 0, 5, 1, 0, 0);
        carry_en = 1'b0;
        scroll_x = -12'sd515;
        set_keys(0, 1, 0);
        frame("clamp_right", 105, 200, 0, 0, 1, 0, 0);
        scroll_x = 12'd85;
        set_keys(1, 0, 0);
        frame("clamp_left", 105, 200, 0, 0, 0, 0, 0);
        scroll_x = -12'sd520;
        set_keys(0, 0, 0);
        blocked_x = 1'b1;
        frame("clamp_over_blk", 100, 200, 0, -5, 0, 0, 0);
        blocked_x = 1'b0;
        scroll_x = '0;
        set_keys(0, 1, 0);
        frame("step", 101, 200, 0, 1, 1, 0, 0);

        set_keys(0, 0, 1);
        frame("jump1", 101, 200, -16, 0, 1, 1, 0);
        blocked_y = 1'b0;
        frame("jump2", 101, 184, -15, 0, 1, 1, 0);
        frame("jump3", 101, 169, -14, 0, 1, 1, 0);
        set_keys(0, 0, 0);
        frame("release", 101, 155, -13, 0, 1, 1, 0);
        set_keys(0, 0, 1);
        frame("air_press", 101, 142, -12, 0, 1, 1, 0);
        blocked_y = 1'b1;
        frame("head_bump", 101, 142, 0, 0, 1, 1, 0);
        frame("land_held", 101, 142, 0, 0, 1, 0, 0);
        frame("still_held", 101, 142, 0, 0, 1, 0, 0);
        set_keys(0, 0, 0);
        frame("released", 101, 142, 0, 0, 1, 0, 0);
        set_keys(0, 0, 1);
        frame("relaunch", 101, 142, -16, 0, 1, 1, 0);

        set_keys(0, 0, 0);
        frame("bump2", 101, 142, 0, 0, 1, 1, 0);
        blocked_y = 1'b0;
        set_keys(0, 0, 1);
        frame("fall_jump", 101, 142, 1, 0, 1, 1, 0);
        set_keys(0, 0, 0);
        ey = 142;
        ev = 1;
        for (int i = 0; i < 20; i++) begin
            ey = ey + ev;
            ev = (ev + 1 > 12) ? 12 : ev + 1;
            frame($sformatf("fall_%0d", i), 101, ey, ev, 0, 1, 1, 0);
        end

        on_platform = 1'b1;
        platform_y  = 12'd430;
        frame("plat_land", 101, 430, 0, 0, 1, 0, 0);
        platform_y  = 12'd435;
        frame("plat_snap", 101, 435, 0, 0, 1, 0, 0);
        on_platform = 1'b0;
        frame("walk_off", 101, 435, 1, 0, 1, 1, 0);
        frame("drop1", 101, 436, 2, 0, 1, 1, 0);
        frame("drop2", 101, 438, 3, 0, 1, 1, 0);
        frame("drop3", 101, 441, 4, 0, 1, 1, 0);
        frame("drop4", 101, 445, 5, 0, 1, 1, 0);
        frame("drop5", 101, 450, 6, 0, 1, 1, 0);
        frame("respawn", 100, 200, 0, -1, 1, 1, 1);
        blocked_y = 1'b1;
        frame("died_clear", 100, 200, 0, 0, 1, 0, 0);

        set_keys(1, 0, 0);
        frame("left2", 99, 200, 0, -1, 0, 0, 0);
        set_keys(0, 0, 1);
        frame("launch_t1", 99, 200, -16, 0, 0, 1, 0);
        blocked_y = 1'b0;
        set_keys(0, 0, 0);
        frame("rise_t1", 99, 184, -15, 0, 0, 1, 0);
        spawn_x = 12'd300;
        spawn_y = 12'd250;
        do_reset("reset_mid_rise", 300, 250);

        blocked_y = 1'b1;
        frame("land3", 300, 250, 0, 0, 1, 0, 0);
        blocked_y = 1'b0;
        frame("ledge_off", 300, 250, 1, 0, 1, 1, 0);
        frame("ledge_f1", 300, 251, 2, 0, 1, 1, 0);
        frame("ledge_f2", 300, 253, 3, 0, 1, 1, 0);
        set_keys(0, 0, 1);
`ifdef PLAYER_COYOTE_EN
        frame("coyote_jump", 300, 253, -16, 0, 1, 1, 0);
        set_keys(0, 0, 0);
        frame("coyote_rise", 300, 237, -15, 0, 1, 1, 0);
        blocked_y = 1'b1;
        frame("coyote_bump", 300, 237, 0, 0, 1, 1, 0);
        frame("coyote_land", 300, 237, 0, 0, 1, 0, 0);
        blocked_y = 1'b0;
        frame("c_walk", 300, 237, 1, 0, 1, 1, 0);
        frame("c_f1", 300, 238, 2, 0, 1, 1, 0);
        frame("c_f2", 300, 240, 3, 0, 1, 1, 0);
        frame("c_f3", 300, 243, 4, 0, 1, 1, 0);
        frame("c_f4", 300, 247, 5, 0, 1, 1, 0);
        set_keys(0, 0, 1);
        frame("c_f5_late", 300, 252, 6, 0, 1, 1, 0);
`else
        frame("no_coyote", 300, 256, 4, 0, 1, 1, 0);
`endif
        set_keys(0, 0, 0);
        on_platform = 1'b1;
        platform_y  = 12'd30;
        frame("plat30", 300, 30, 0, 0, 1, 0, 0);
        set_keys(0, 0, 1);
        frame("jump30", 300, 30, -16, 0, 1, 1, 0);
        on_platform = 1'b0;
        set_keys(0, 0, 0);
        frame("y_min", 300, 25, 0, 0, 1, 1, 0);
        frame("y_min_fall", 300, 25, 1, 0, 1, 1, 0);

        repeat (2) @(negedge frame_clk);
        if (q.size() != 0) begin
            $display("FAIL drain: %0d expectations never checked, want 0",
                     q.size());
            tests += q.size();
            fails += q.size();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
